// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the mux_2to1 slice.
// The optional self-checker is built only when MUX_CHECK_EN is defined.
package mux_pkg;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned MAX_VECTORS_DEF = 8;

    // Increment a counter of width w (1..31), holding it at 2**w-1 instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
        logic [31:0] max_val;
        max_val = (32'd1 << w) - 32'd1;
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/mux_checker.sv
// Built-in self-check: counts applied and mismatched vectors and flags completion.
// Instantiated by mux_2to1 only when MUX_CHECK_EN is defined.
module mux_checker
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MAX_VECTORS = MAX_VECTORS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_vld,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] y_exp,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             done
);

    logic [31:0] vec_inc;
    logic [31:0] err_inc;
    logic [CNT_W-1:0] vec_nxt;
    logic [CNT_W-1:0] err_nxt;

    always_comb begin
        vec_inc = sat_inc(32'(vec_cnt), CNT_W);
        err_inc = sat_inc(32'(err_cnt), CNT_W);
        vec_nxt = vec_inc[CNT_W-1:0];
        err_nxt = err_inc[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vec_cnt <= '0;
            err_cnt <= '0;
            done    <= 1'b0;
        end else if (chk_vld) begin
            vec_cnt <= vec_nxt;
            if (y != y_exp) begin
                err_cnt <= err_nxt;
            end
            // Sticky: once the target count is reached only reset clears it.
            done <= done | (32'(vec_nxt) >= MAX_VECTORS);
        end
    end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 selector with combinational and 1-cycle registered outputs.
// Define MUX_CHECK_EN to add the vector-counting self-checker and its ports.
module mux_2to1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH       = 1
`ifdef MUX_CHECK_EN
    ,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MAX_VECTORS = MAX_VECTORS_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
`ifdef MUX_CHECK_EN
    ,
    input  logic             chk_vld,
    input  logic [WIDTH-1:0] y_exp,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             done
`endif
);

    assign y = sel ? b : a;

    // NOTE: reset is sampled on the clock edge (synchronous), and state uses <= so every
    // register sees pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

`ifdef MUX_CHECK_EN
    mux_checker #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .MAX_VECTORS (MAX_VECTORS)
    ) u_checker (
        .clk     (clk),
        .rst     (rst),
        .chk_vld (chk_vld),
        .y       (y),
        .y_exp   (y_exp),
        .vec_cnt (vec_cnt),
        .err_cnt (err_cnt),
        .done    (done)
    );
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: truth table, registered path, reset, and
// (when MUX_CHECK_EN is defined) checker counting, stickiness and saturation.
module tb_mux_2to1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic sel = 1'b0;
    logic y;
    logic y_q;

    always #5 clk = ~clk;

`ifdef MUX_CHECK_EN
    logic       chk_vld = 1'b0;
    logic       y_exp   = 1'b0;
    logic [7:0] vec_cnt;
    logic [7:0] err_cnt;
    logic       done;

    logic       chk_vld_s = 1'b0;
    logic       y_exp_s   = 1'b0;
    logic       y_s;
    logic       y_q_s;
    logic [1:0] vec_cnt_s;
    logic [1:0] err_cnt_s;
    logic       done_s;
`endif

    mux_2to1 #(
        .WIDTH (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .y       (y),
        .y_q     (y_q)
`ifdef MUX_CHECK_EN
        ,
        .chk_vld (chk_vld),
        .y_exp   (y_exp),
        .vec_cnt (vec_cnt),
        .err_cnt (err_cnt),
        .done    (done)
`endif
    );

`ifdef MUX_CHECK_EN
    mux_2to1 #(
        .WIDTH       (1),
        .CNT_W       (2),
        .MAX_VECTORS (8)
    ) dut_s (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .y       (y_s),
        .y_q     (y_q_s),
        .chk_vld (chk_vld_s),
        .y_exp   (y_exp_s),
        .vec_cnt (vec_cnt_s),
        .err_cnt (err_cnt_s),
        .done    (done_s)
    );
`endif

    typedef struct {
        logic a;
        logic b;
        logic sel;
        logic y;
    } vec_t;

    vec_t tv[8];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{a: 1'b0, b: 1'b0, sel: 1'b0, y: 1'b0};
        tv[1] = '{a: 1'b0, b: 1'b0, sel: 1'b1, y: 1'b0};
        tv[2] = '{a: 1'b0, b: 1'b1, sel: 1'b0, y: 1'b0};
        tv[3] = '{a: 1'b0, b: 1'b1, sel: 1'b1, y: 1'b1};
        tv[4] = '{a: 1'b1, b: 1'b0, sel: 1'b0, y: 1'b1};
        tv[5] = '{a: 1'b1, b: 1'b0, sel: 1'b1, y: 1'b0};
        tv[6] = '{a: 1'b1, b: 1'b1, sel: 1'b0, y: 1'b1};
        tv[7] = '{a: 1'b1, b: 1'b1, sel: 1'b1, y: 1'b1};

        // Reset with a selected value of 1: y follows inputs, y_q held at zero.
        rst = 1'b0; a = 1'b1; b = 1'b0; sel = 1'b0;
        tick();
        tick();
        check("reset_y_q", 32'(y_q), 32'd0);
        check("reset_y",   32'(y),   32'd1);
`ifdef MUX_CHECK_EN
        check("reset_vec_cnt", 32'(vec_cnt), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_done",    32'(done),    32'd0);
`endif
        rst = 1'b1;

        // Truth table: combinational y immediately, y_q after the next edge.
        for (int i = 0; i < 8; i++) begin
            a = tv[i].a; b = tv[i].b; sel = tv[i].sel;
            #1;
            check($sformatf("tt_y[%0d]", i), 32'(y), 32'(tv[i].y));
            tick();
            check($sformatf("tt_y_q[%0d]", i), 32'(y_q), 32'(tv[i].y));
        end

        // Registered path latency.
        a = 1'b1; b = 1'b0; sel = 1'b0;
        tick();
        check("reg_y_q_a", 32'(y_q), 32'd1);
        sel = 1'b1;
        #1;
        check("reg_y_now",     32'(y),   32'd0);
        check("reg_y_q_holds", 32'(y_q), 32'd1);
        tick();
        check("reg_y_q_b", 32'(y_q), 32'd0);

        // Mid-operation reset.
        a = 1'b1; b = 1'b1; sel = 1'b0;
        tick();
        check("mid_pre_y_q", 32'(y_q), 32'd1);
        rst = 1'b0;
        tick();
        check("mid_rst_y_q", 32'(y_q), 32'd0);
        check("mid_rst_y",   32'(y),   32'd1);
        rst = 1'b1;
        tick();
        check("mid_rel_y_q", 32'(y_q), 32'd1);

`ifdef MUX_CHECK_EN
        check("idle_vec_cnt", 32'(vec_cnt), 32'd0);

        // Eight correct vectors.
        for (int i = 0; i < 8; i++) begin
            a = tv[i].a; b = tv[i].b; sel = tv[i].sel;
            y_exp = tv[i].y; chk_vld = 1'b1;
            tick();
            if (i == 6) begin
                check("chk_vec_cnt_7", 32'(vec_cnt), 32'd7);
                check("chk_done_at_7", 32'(done),    32'd0);
            end
        end
        chk_vld = 1'b0;
        check("chk_vec_cnt_8", 32'(vec_cnt), 32'd8);
        check("chk_err_cnt_0", 32'(err_cnt), 32'd0);
        tick();
        check("chk_done",      32'(done),    32'd1);
        check("chk_vec_hold",  32'(vec_cnt), 32'd8);

        // One mismatch, then idle cycles with a wrong y_exp.
        a = 1'b1; b = 1'b0; sel = 1'b0; y_exp = 1'b0; chk_vld = 1'b1;
        tick();
        chk_vld = 1'b0;
        check("err_err_cnt_1", 32'(err_cnt), 32'd1);
        check("err_vec_cnt_9", 32'(vec_cnt), 32'd9);
        for (int i = 0; i < 3; i++) tick();
        check("idle_err_hold",  32'(err_cnt), 32'd1);
        check("idle_vec_hold",  32'(vec_cnt), 32'd9);
        check("idle_done_hold", 32'(done),    32'd1);

        // Saturation on the CNT_W=2 instance: five mismatching vectors.
        for (int i = 0; i < 5; i++) begin
            a = tv[i].a; b = tv[i].b; sel = tv[i].sel;
            y_exp_s = ~tv[i].y; chk_vld_s = 1'b1;
            tick();
            if (i == 1) begin
                check("sat_vec_cnt_2", 32'(vec_cnt_s), 32'd2);
                check("sat_err_cnt_2", 32'(err_cnt_s), 32'd2);
            end
        end
        chk_vld_s = 1'b0;
        check("sat_vec_cnt", 32'(vec_cnt_s), 32'd3);
        check("sat_err_cnt", 32'(err_cnt_s), 32'd3);
        check("sat_done",    32'(done_s),    32'd0);

        // Reset clears checker state.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst2_vec_cnt", 32'(vec_cnt), 32'd0);
        check("rst2_err_cnt", 32'(err_cnt), 32'd0);
        check("rst2_done",    32'(done),    32'd0);
        check("rst2_sat_vec", 32'(vec_cnt_s), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
